// File: rtl/inmem_pkg.sv
// Shared definitions for the input memory frontend.
// - state_e      : frontend control states
// - latency bounds for the read pipeline
// - bit positions inside the sticky error vector
// - addr_oob()   : out-of-range read address test
package inmem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StArm,
    StRun,
    StDone
  } state_e;

  localparam int unsigned MinAccessLatency = 1;
  localparam int unsigned MaxAccessLatency = 8;

  localparam int unsigned ErrOobBit  = 0;
  localparam int unsigned ErrWrBit   = 1;
  localparam int unsigned NumErrBits = 2;

  function automatic logic addr_oob(input logic [31:0] addr, input int unsigned depth);
    return addr >= depth;
  endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Fixed-latency read pipeline: carries raw RAM read data plus a zero mask so
// that out-of-range or illegal reads come out as 0 at the normal latency.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high flush
//   i_data       : raw read data sampled this cycle
//   i_zero       : force this read's result to 0
//   o_data       : read result, LATENCY cycles after sampling
module mem_read_pipe
  import inmem_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_zero,
  output logic [WIDTH-1:0] o_data
);

  if (LATENCY < MinAccessLatency || LATENCY > MaxAccessLatency) begin : g_bad_latency
    $error("mem_read_pipe: LATENCY out of range");
  end

  logic [WIDTH-1:0] r_data [LATENCY];
  logic             r_zero [LATENCY];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        r_data[i] <= '0;
        r_zero[i] <= 1'b0;
      end
    end else begin
      r_data[0] <= i_data;
      r_zero[0] <= i_zero;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_data[i] <= r_data[i-1];
        r_zero[i] <= r_zero[i-1];
      end
    end
  end

  assign o_data = r_zero[LATENCY-1] ? '0 : r_data[LATENCY-1];

endmodule

// File: rtl/input_mem_frontend.sv
// Input memory frontend: loads a host word stream into the input RAM, arms
// and starts the matmul FSM, serves its fixed-latency reads and tracks job
// completion. Protocol errors are kept as sticky flags.
// Ports:
//   i_clk, i_rst                      : clock, synchronous active-high reset
//   i_host_wr_valid/_data/_last,
//   o_host_wr_ready                   : host load stream
//   i_bisr_req, o_bisr_en             : BISR request, latched per job
//   o_start_fsm, i_fsm_rdy, i_fsm_done: matmul FSM handshake
//   i_mem_addr, i_mem_wr_en,
//   o_mem_rd_data                     : FSM read port
//   o_loaded_words                    : word count of the last load
//   o_job_done, o_busy                : job status
//   o_err_oob, o_err_wr               : sticky protocol errors
module input_mem_frontend
  import inmem_pkg::*;
#(
  parameter int unsigned MEM_PORT_WIDTH     = 64,
  parameter int unsigned DEPTH              = 64,
  parameter int unsigned MEM_ACCESS_LATENCY = 2,
  parameter int unsigned CNT_W              = $clog2(DEPTH) + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_host_wr_valid,
  output logic                      o_host_wr_ready,
  input  logic [MEM_PORT_WIDTH-1:0] i_host_wr_data,
  input  logic                      i_host_wr_last,
  input  logic                      i_bisr_req,
  output logic                      o_start_fsm,
  output logic                      o_bisr_en,
  input  logic                      i_fsm_rdy,
  input  logic                      i_fsm_done,
  input  logic [31:0]               i_mem_addr,
  input  logic                      i_mem_wr_en,
  output logic [MEM_PORT_WIDTH-1:0] o_mem_rd_data,
  output logic [CNT_W-1:0]          o_loaded_words,
  output logic                      o_job_done,
  output logic                      o_busy,
  output logic                      o_err_oob,
  output logic                      o_err_wr
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          r_loaded_words;
  logic                      r_start_fsm;
  logic                      r_job_done;
  logic                      r_bisr_en;
  logic                      r_fsm_done_q;
  logic [NumErrBits-1:0]     r_err;
  logic [MEM_PORT_WIDTH-1:0] r_mem [DEPTH];

  logic                      w_wr_fire;
  logic [AW-1:0]             w_wr_addr;
  logic [CNT_W-1:0]          w_cnt_next;
  logic                      w_load_end;
  logic                      w_oob;
  logic                      w_err_clr;
  logic [NumErrBits-1:0]     w_err_set;
  logic [MEM_PORT_WIDTH-1:0] w_rd_raw;

  // Ready is held low while reset is asserted so no word can slip in.
  always_comb begin
    o_host_wr_ready = 1'b0;
    if (!i_rst) begin
      if (r_state == StIdle) begin
        o_host_wr_ready = 1'b1;
      end else if (r_state == StLoad) begin
        o_host_wr_ready = r_cnt < CNT_W'(DEPTH);
      end
    end
  end

  assign w_wr_fire  = i_host_wr_valid && o_host_wr_ready;
  // The first word of a load always lands at address 0.
  assign w_wr_addr  = (r_state == StIdle) ? '0 : r_cnt[AW-1:0];
  assign w_cnt_next = (r_state == StIdle) ? CNT_W'(1) : r_cnt + CNT_W'(1);
  // The DEPTH-th word closes the load even without last.
  assign w_load_end = i_host_wr_last || (w_cnt_next == CNT_W'(DEPTH));

  assign w_oob     = addr_oob(i_mem_addr, DEPTH);
  assign w_err_clr = w_wr_fire && (r_state == StIdle);
  always_comb begin
    w_err_set            = '0;
    w_err_set[ErrOobBit] = w_oob;
    w_err_set[ErrWrBit]  = i_mem_wr_en;
  end

  // Storage only; no reset on the array.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      r_mem[w_wr_addr] <= i_host_wr_data;
    end
  end

  // Asynchronous array read feeds the pipe before this edge's write lands,
  // which gives read-before-write on a same-address collision.
  assign w_rd_raw = r_mem[i_mem_addr[AW-1:0]];

  mem_read_pipe #(
    .WIDTH  (MEM_PORT_WIDTH),
    .LATENCY(MEM_ACCESS_LATENCY)
  ) u_read_pipe (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_data(w_rd_raw),
    .i_zero(w_oob || i_mem_wr_en),
    .o_data(o_mem_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_loaded_words <= '0;
      r_start_fsm    <= 1'b0;
      r_job_done     <= 1'b0;
      r_bisr_en      <= 1'b0;
      r_fsm_done_q   <= 1'b0;
      r_err          <= '0;
    end else begin
      r_start_fsm  <= 1'b0;
      r_job_done   <= 1'b0;
      r_fsm_done_q <= i_fsm_done;
      // A new load wipes old errors; errors raised in that same cycle still stick.
      r_err        <= (w_err_clr ? '0 : r_err) | w_err_set;
      unique case (r_state)
        StIdle, StLoad: begin
          if (w_wr_fire) begin
            r_cnt <= w_cnt_next;
            if (w_load_end) begin
              r_state        <= StArm;
              r_loaded_words <= w_cnt_next;
              r_bisr_en      <= i_bisr_req;
            end else begin
              r_state <= StLoad;
            end
          end
        end
        StArm: begin
          if (i_fsm_rdy) begin
            r_start_fsm <= 1'b1;
            r_state     <= StRun;
          end
        end
        StRun: begin
          // A level already high on entry must drop before it can count.
          if (i_fsm_done && !r_fsm_done_q) begin
            r_job_done <= 1'b1;
            r_state    <= StDone;
          end
        end
        StDone: begin
          r_bisr_en <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_start_fsm    = r_start_fsm;
  assign o_job_done     = r_job_done;
  assign o_bisr_en      = r_bisr_en;
  assign o_loaded_words = r_loaded_words;
  assign o_busy         = r_state != StIdle;
  assign o_err_oob      = r_err[ErrOobBit];
  assign o_err_wr       = r_err[ErrWrBit];

endmodule

// File: doc/input_mem_frontend.md
Name: input_mem_frontend

Overview:
- Upstream stage of the BISR systolic top. Owns the input RAM that the matmul FSM reads via mem_addr/mem_rd_data.
- Accepts a host stream of packed input words into the RAM, then arms and pulses start_fsm.
- Serves FSM reads with a fixed MEM_ACCESS_LATENCY pipeline, and tracks job completion via fsm_done.
- Flags protocol errors: out-of-range reads and unexpected write requests.

Parameters:
- MEM_PORT_WIDTH, 64, width of one RAM word (ROWS*WORD_SIZE for 4x16).
- DEPTH, 64, number of RAM words; power of two.
- MEM_ACCESS_LATENCY, 2, cycles from mem_addr sample to mem_rd_data valid; legal range 1..8.
- CNT_W, $clog2(DEPTH)+1, width of the word counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- host_wr_valid  in  1  host word valid.
- host_wr_ready  out  1  frontend accepts a host word this cycle.
- host_wr_data  in  MEM_PORT_WIDTH  host word.
- host_wr_last  in  1  final word of the load.
- bisr_req  in  1  host request to run this job with BISR; sampled at load end.
- start_fsm  out  1  one-cycle start pulse to the matmul FSM.
- bisr_en  out  1  latched bisr_req, held for the whole job.
- fsm_rdy  in  1  matmul FSM idle/ready.
- fsm_done  in  1  matmul FSM done (level or pulse).
- mem_addr  in  32  FSM read address (word index).
- mem_wr_en  in  1  FSM write strobe; illegal on this RAM.
- mem_rd_data  out  MEM_PORT_WIDTH  read data.
- loaded_words  out  CNT_W  number of words stored by the last load.
- job_done  out  1  one-cycle pulse at job completion.
- busy  out  1  state != IDLE.
- err_oob  out  1  sticky: a read was issued with mem_addr >= DEPTH.
- err_wr  out  1  sticky: mem_wr_en was seen high.

Behaviour:
- Reset values: all outputs 0, state IDLE, word counter 0, read pipeline flushed. RAM contents are NOT reset.
- States: IDLE, LOAD, ARM, RUN, DONE.
- IDLE:
  - host_wr_ready=1.
  - An accepted word (valid&&ready) writes RAM[0], sets counter=1 and goes to LOAD.
  - If that word also has last=1, go straight to ARM.
- LOAD:
  - host_wr_ready=1 while counter<DEPTH; each accepted word writes RAM[counter], then counter++.
  - Exit to ARM on an accepted word with last=1, or when counter reaches DEPTH (the DEPTH-th word ends the load even without last).
  - On exit: loaded_words<=final count; bisr_en<=bisr_req sampled that cycle.
- ARM:
  - host_wr_ready=0.
  - When fsm_rdy=1, drive start_fsm=1 for exactly one cycle and go to RUN.
- RUN:
  - host_wr_ready=0.
  - Go to DONE on the rising edge of fsm_done (fsm_done registered; edge = fsm_done && !fsm_done_q).
  - fsm_done already high on RUN entry does not count until it has been seen low.
- DONE:
  - job_done=1 for one cycle, bisr_en<=0, then IDLE.
- Read path:
  - Every cycle, mem_addr is sampled and RAM[mem_addr] appears on mem_rd_data exactly MEM_ACCESS_LATENCY cycles later. Reads are independent of state.
  - mem_addr >= DEPTH returns 0 at the same latency and sets err_oob.
  - A read in the same cycle as a host write to the same address returns old data (read-before-write).
- mem_wr_en=1 sets err_wr; the read issued that cycle returns 0 and no RAM write occurs.
- err_oob and err_wr clear only on rst, or on entry to LOAD from IDLE.
- rst mid-job:
  - All state aborts to IDLE and start_fsm/job_done/bisr_en drop on the next edge.
  - Read data already in the pipeline is discarded (mem_rd_data=0).
- host_wr_valid with ready=0 is held off: no write, no counter change.

Decomposition:
- Package inmem_pkg: state enum (IDLE, LOAD, ARM, RUN, DONE), MEM_ACCESS_LATENCY bounds, error-code bit positions.
- One sub-module: mem_read_pipe, a MEM_ACCESS_LATENCY-deep register chain carrying read data plus an oob-zero mask, with synchronous flush.

Test Plan:
- Load 16 words (word i = 64'h1000+i, last on i=15) with fsm_rdy=1 -> loaded_words=16, start_fsm pulses once 1 cycle after ARM entry, busy=1.
- With L=2, drive mem_addr=5 at cycle t -> mem_rd_data=64'h1005 at t+2. mem_addr=70 -> 0 at t+2 and err_oob=1.
- Load 64 words without last -> load ends after word 63, host_wr_ready=0, a 65th valid is ignored, loaded_words=64.
- bisr_req=1 at last word, fsm_rdy held 0 for 5 cycles -> start_fsm held off until fsm_rdy rises; bisr_en=1 through RUN.
- fsm_done high on RUN entry, low 1 cycle, high again -> job_done pulses once after the second rise; bisr_en=0, state IDLE.
- rst asserted in RUN with reads in flight, and mem_wr_en pulse before that -> err_wr=1 before reset; after reset all outputs 0 and RAM[5] still reads 64'h1005.
